coproc_pixel_stream: RTL
========================

Name: coproc_pixel_stream

Overview:
- Frame-level sequencer for the image coprocessor.
- On a start pulse it reads every pixel of a source frame from the frame buffer and presents each pixel, with a latched function code, to the combinational pixel ALU. It writes each ALU result to a destination frame.
- Sits between the CPU-facing coprocessor control registers and the per-pixel ALU. It is the stage that directly feeds the ALU and consumes its output.

Parameters:
- IMG_W, 320, frame width in pixels
- IMG_H, 240, frame height in pixels
- ADDR_W, 17, frame-buffer word address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- PIX_W, 12, pixel width (4:4:4 RGB)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to process a frame
- func  in  2  ALU function: 00 invert, 01 colour map, 10 contrast, 11 threshold
- src_base  in  ADDR_W  first source pixel address
- dst_base  in  ADDR_W  first destination pixel address
- stall  in  1  frame-buffer arbitration hold; freezes the block
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last write
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  PIX_W  read data, valid the cycle after rd_en; the buffer holds it while rd_en=0
- alu_pixel  out  PIX_W  pixel to ALU
- alu_func  out  2  latched function to ALU
- alu_result  in  PIX_W  combinational ALU output
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  PIX_W  write data (= alu_result)

Behaviour:
- Reset is asynchronous and active-high. All registers clear, state = IDLE, and every output is 0.
- N = IMG_W*IMG_H. Address arithmetic is unsigned modulo 2^ADDR_W; wrap past the top is legal and not flagged.
- States:
  - IDLE: start=1 latches func, src_base, dst_base, clears rd_idx/wr_idx, goes to RUN. start is ignored in all other states.
  - RUN: each non-stalled cycle, rd_en=1, rd_addr=src_q+rd_idx, then rd_idx increments. After issuing rd_idx=N-1, go to DRAIN.
  - DRAIN: no reads; wait for the pipeline to empty (both valid bits 0), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN and DRAIN; 0 in IDLE and DONE.
- Pipeline, two stages:
  - v1: set the cycle after a read issues. pix_q <= rd_data at the end of that cycle, v2 <= v1.
  - While v2=1: alu_pixel=pix_q, wr_en=1, wr_addr=dst_q+wr_idx, wr_data=alu_result; wr_idx increments.
  - Read-to-write latency is 2 cycles. Throughput is 1 pixel/cycle.
- alu_func = latched func during the whole frame; the func input is ignored after start. alu_pixel = pix_q (0 after reset).
- Stall: while stall=1, rd_en=0, wr_en=0, and the state, indices, valid bits and pix_q all hold. Processing resumes the first cycle stall=0 with no pixel lost or duplicated.
- Timing with no stall, start sampled at cycle 0:
  - reads occur in cycles 1..N
  - writes occur in cycles 3..N+2
  - done occurs in cycle N+3
  - busy is high in cycles 1..N+2
- start and stall together in IDLE: start is accepted. The first RUN cycle is still frozen if stall persists.
- Reset mid-frame: immediate abort, no further rd_en or wr_en. A partially written destination is acceptable.
- Overlapping src/dst (same base) is legal: each address is read 2 cycles before it is written.

Test Plan:
- IMG_W=4, IMG_H=2, src=0x10, dst=0x40, func=00, pixels 0x000..0x007, invert ALU model:
  - rd_addr 0x10..0x17 in cycles 1..8
  - wr_addr 0x40..0x47 in cycles 3..10, data 0xFFF..0xFF8
  - done pulse in cycle 11
- Same setup with stall=1 in cycles 4-6: every event after cycle 3 shifts by 3 cycles; the 8 writes are identical, with no gaps in data order; done in cycle 14.
- start pulsed again in cycle 5 with func=11: ignored; alu_func stays 00 and the write count stays 8.
- src=dst=0x1FFFE (ADDR_W=17): rd/wr addresses run 0x1FFFE, 0x1FFFF, 0x00000..0x00005 (wrap).
- rst asserted in cycle 5 asynchronously: all outputs 0 before the next edge, no writes follow, and busy=0. A fresh start afterwards completes normally.
- Back-to-back frames: start the cycle after done; the second frame's reads begin the following cycle, and both frames produce N writes each.

Source files
------------

// File: rtl/coproc_pixel_stream.sv
// Frame-level sequencer: streams every source pixel through the pixel ALU
// and writes each result to the destination frame, one pixel per cycle.
module coproc_pixel_stream #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        func,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  alu_pixel,
  output logic [1:0]        alu_func,
  input  logic [PIX_W-1:0]  alu_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state;
  logic [1:0]        func_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              v1;
  logic              v2;
  logic [PIX_W-1:0]  pix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      func_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      pix_q  <= '0;
    end else if (state == IDLE) begin
      // start is honoured in IDLE even under stall; the first RUN cycle then freezes
      if (start) begin
        func_q <= func;
        src_q  <= src_base;
        dst_q  <= dst_base;
        rd_idx <= '0;
        wr_idx <= '0;
        state  <= RUN;
      end
    end else if (!stall) begin
      v1 <= (state == RUN);
      v2 <= v1;
      if (v1) pix_q <= rd_data;
      if (v2) wr_idx <= wr_idx + 1'b1;
      unique case (state)
        RUN: begin
          rd_idx <= rd_idx + 1'b1;
          if (rd_idx == LAST_IDX) state <= DRAIN;
        end
        // v2 takes v1 this edge, so v1=0 here means both stages are empty next cycle
        DRAIN: if (!v1) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= state;
      endcase
    end
  end

  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE) && !stall;
    rd_en     = (state == RUN) && !stall;
    rd_addr   = '0;
    wr_en     = v2 && !stall;
    wr_addr   = '0;
    wr_data   = '0;
    alu_pixel = pix_q;
    alu_func  = func_q;
    if (rd_en) rd_addr = src_q + rd_idx;
    if (wr_en) begin
      wr_addr = dst_q + wr_idx;
      wr_data = alu_result;
    end
  end

endmodule
